sound_pong: RTL
===============

// Module: sound_pong
// PURPOSE
//  Sound back-end for the pong game: consumes the (mute, code_sound) pair driven by the
//  game-dynamics block and generates a square-wave speaker output. One-shot tones for
//  ping (wall bounce) and pong (paddle hit); a two-tone rising "go" jingle for serve.
//  Sits between dynamic_pong and the board buzzer/speaker pin.
// PARAMETERS
//  CNT_W      20      width of half-period counter (bits)
//  DUR_W      24      width of duration counter (bits)
//  PING_HALF  25000   half-period of ping tone, clk cycles (500 Hz @ 25 MHz)
//  PONG_HALF  50000   half-period of pong tone, clk cycles (250 Hz)
//  GO_HALF_A  62500   half-period, first go tone (200 Hz)
//  GO_HALF_B  31250   half-period, second go tone (400 Hz)
//  DUR        2500000 duration of every tone segment, clk cycles (100 ms)
// PORTS
//  clk         in   1  system clock
//  clr         in   1  reset, synchronous, active-high
//  mute        in   1  1 = silence; aborts current sound, blocks new ones
//  code_sound  in   2  10 ping, 01 pong, 11 go, 00 stop (level, from dynamic_pong)
//  speaker     out  1  square-wave audio output (registered)
//  busy        out  1  1 while a sound is being played (registered)
// BEHAVIOUR
//  Interface decided: one clock; reset is synchronous and active-high (clk, clr).
//  - Reset (clr=1 at edge): state IDLE, speaker=0, busy=0, counters=0, code_q=stop.
//  - code_q: register of code_sound, updated every cycle (also while muted/busy).
//  - Event: code_sound != code_q && code_sound != stop && mute==0. Level held = one event;
//    stop->X or X->Y change = new event. stop itself never plays nor aborts.
//  - FSM states: IDLE, TONE (ping/pong, half latched from code), GO_A, GO_B.
//  - Priority per edge: clr > mute > event > counting.
//  - mute=1: next edge -> IDLE, speaker=0, busy=0. Events during mute are lost.
//  - Event (any state, incl. busy = preempt/restart): next edge -> TONE or GO_A,
//    busy=1, speaker=0, half_cnt=0, dur_cnt=0, half value latched.
//  - Counting (non-IDLE): half_cnt++; at half_cnt==half-1 toggle speaker, half_cnt=0.
//    dur_cnt++; at dur_cnt==DUR-1: TONE/GO_B -> IDLE (speaker=0, busy=0);
//    GO_A -> GO_B (counters=0, speaker=0, half=GO_HALF_B).
//  - Timing: busy high exactly DUR cycles (ping/pong), 2*DUR (go); first speaker rise
//    HALF cycles after busy rises; period 2*HALF. Event-to-busy latency 1 cycle.
//  - Counters never wrap: reloaded before overflow; params must fit CNT_W/DUR_W.
//  - IDLE: speaker held 0 (no DC on buzzer).
// STRUCTURE
//  - Shared include pong_defs.vh: sound codes ping/pong/go/stop (also used by
//    dynamic_pong), screen/ball constants; FSM state encodings local to this module.
//  - One sub-module: tone_divider (load, half, en -> square out, reusable counter).
//  - Top: code_q edge detect, FSM, duration counter, output registers.
// TESTING  (params: PING_HALF=4, PONG_HALF=6, GO_HALF_A=3, GO_HALF_B=2, DUR=40)
//  1 code 00->10 -> busy=1 next cycle for 40 cycles, speaker period 8 (5 highs), then 0.
//  2 code 00->11 -> busy 80 cycles; first 40 period 6, next 40 period 4; speaker=0 at end.
//  3 ping, at cycle 10 code 10->01 -> restart: busy continuous, 40 more cycles, period 12.
//  4 ping, mute=1 at cycle 15 -> speaker=0, busy=0 next edge; mute=0 with code held
//    -> no replay; then 10->00->10 -> replays ping.
//  5 clr mid go (cycle 50) -> IDLE, outputs 0; code held at 11 after clr -> go replays.
//  6 code held 01 for 200 cycles -> exactly one pong; 01->00 during play -> no abort.

Source files
------------

// File: rtl/sound_pong_pkg.sv
// Shared sound codes for the pong game; the same encoding is driven by dynamic_pong.
package sound_pong_pkg;

  localparam logic [1:0] SND_STOP = 2'b00;
  localparam logic [1:0] SND_PONG = 2'b01;
  localparam logic [1:0] SND_PING = 2'b10;
  localparam logic [1:0] SND_GO   = 2'b11;

  function automatic logic is_sound(input logic [1:0] code);
    return code != SND_STOP;
  endfunction

endpackage

// File: rtl/sound_pong_tone_divider.sv
// Reloadable half-period divider producing a registered square wave.
module tone_divider #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             sq_o
);

  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sq_q;

  // load restarts the wave low with a fresh half-period; it also serves as the clear
  always_ff @(posedge clk) begin
    if (load_i) begin
      half_q <= half_i;
      cnt_q  <= '0;
      sq_q   <= 1'b0;
    end else if (en_i) begin
      if (cnt_q == half_q - CNT_W'(1)) begin
        cnt_q <= '0;
        sq_q  <= ~sq_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sq_o = sq_q;

endmodule

// File: rtl/sound_pong.sv
// Pong sound back-end: turns (mute, code_sound) into one-shot square-wave tones and a go jingle.
module sound_pong
  import sound_pong_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int DUR_W     = 24,
  parameter int PING_HALF = 25000,
  parameter int PONG_HALF = 50000,
  parameter int GO_HALF_A = 62500,
  parameter int GO_HALF_B = 31250,
  parameter int DUR       = 2500000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       mute,
  input  logic [1:0] code_sound,
  output logic       speaker,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GO_A = 2'd2,
    S_GO_B = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [1:0]       code_q;
  logic             load_c;
  logic             en_c;
  logic [CNT_W-1:0] half_c;
  logic             event_c;

  function automatic logic [CNT_W-1:0] code_half(input logic [1:0] code);
    case (code)
      SND_PING: return CNT_W'(PING_HALF);
      SND_PONG: return CNT_W'(PONG_HALF);
      default:  return CNT_W'(GO_HALF_A);
    endcase
  endfunction

  // A held level is one event; only a change to a non-stop code starts a sound.
  assign event_c = (code_sound != code_q) && is_sound(code_sound) && !mute;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      dur_q   <= '0;
      code_q  <= SND_STOP;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      dur_q   <= dur_d;
      code_q  <= code_sound;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    dur_d   = dur_q;
    load_c  = 1'b0;
    en_c    = 1'b0;
    half_c  = code_half(code_sound);
    if (mute) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      dur_d   = '0;
      load_c  = 1'b1;
    end else if (event_c) begin
      state_d = (code_sound == SND_GO) ? S_GO_A : S_TONE;
      busy_d  = 1'b1;
      dur_d   = '0;
      load_c  = 1'b1;
    end else if (state_q != S_IDLE) begin
      if (dur_q == DUR_W'(DUR - 1)) begin
        dur_d  = '0;
        load_c = 1'b1;
        if (state_q == S_GO_A) begin
          state_d = S_GO_B;
          half_c  = CNT_W'(GO_HALF_B);
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end else begin
        dur_d = dur_q + DUR_W'(1);
        en_c  = 1'b1;
      end
    end
  end

  tone_divider #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk   (clk),
    .load_i(clr | load_c),
    .en_i  (en_c),
    .half_i(half_c),
    .sq_o  (speaker)
  );

  assign busy = busy_q;

endmodule
